// File: rtl/alu_hs_core.sv
// Handshaked unsigned ALU: add/sub/mul complete in one cycle, div uses a restoring
// divider that retires one quotient bit per clock. Results are held until taken.
module alu_hs_core #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [WIDTH-1:0] ALU_Hi,
    output logic             CarryOut,
    output logic             Zero,
    output logic             DivByZero,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a request or result is consumed only by that transfer.

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic             accept;

    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_out, res_hi;
    logic             res_c, res_dbz, start_div;

    logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_sh, trial;
    logic             q_bit, last_step;
    logic [WIDTH-1:0] rem_nx, dvd_nx;

    assign in_ready  = (state == S_IDLE) & ~reset;
    assign out_valid = (state == S_HOLD);
    assign state_dbg = state;
    assign accept    = in_valid & in_ready;

    // Single-cycle result, computed straight from the operands presented at accept.
    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        prod      = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        res_out   = '1;
        res_hi    = '0;
        res_c     = 1'b0;
        res_dbz   = 1'b0;
        start_div = 1'b0;
        case (ALU_Sel)
            4'b0001: begin
                res_out = sum[WIDTH-1:0];
                res_c   = sum[WIDTH];
            end
            4'b0010: begin
                res_out = A - B;
                res_c   = (A < B);
            end
            4'b0100: begin
                res_out = prod[WIDTH-1:0];
                res_hi  = prod[2*WIDTH-1:WIDTH];
                res_c   = |prod[2*WIDTH-1:WIDTH];
            end
            4'b1000: begin
                if (B == '0) begin
                    res_hi  = A;
                    res_dbz = 1'b1;
                end else begin
                    start_div = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // One restoring step; the dividend register shifts left and collects quotient bits.
    always_comb begin
        rem_sh    = {rem_q, dvd_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, dvs_q};
        q_bit     = ~trial[WIDTH];
        rem_nx    = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nx    = {dvd_q[WIDTH-2:0], q_bit};
        last_step = (cnt_q == CW'(1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = start_div ? S_DIV : S_HOLD;
            S_DIV:  if (last_step) state_nx = S_HOLD;
            S_HOLD: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ALU_Out   <= '0;
            ALU_Hi    <= '0;
            CarryOut  <= 1'b0;
            Zero      <= 1'b0;
            DivByZero <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            if (start_div) begin
                dvd_q <= A;
                dvs_q <= B;
                rem_q <= '0;
                cnt_q <= CW'(WIDTH);
            end else begin
                ALU_Out   <= res_out;
                ALU_Hi    <= res_hi;
                CarryOut  <= res_c;
                Zero      <= (res_out == '0);
                DivByZero <= res_dbz;
            end
        end else if (state == S_DIV) begin
            dvd_q <= dvd_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CW'(1);
            if (last_step) begin
                ALU_Out   <= dvd_nx;
                ALU_Hi    <= rem_nx;
                CarryOut  <= 1'b0;
                Zero      <= (dvd_nx == '0);
                DivByZero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_hs_core.sv
// Directed bench for alu_hs_core (WIDTH=8): per-op results, latencies, back-pressure
// and reset in the middle of a division.
module tb_alu_hs_core;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic [3:0] ALU_Sel = 4'd0;
    logic       in_ready, out_valid, CarryOut, Zero, DivByZero;
    logic [7:0] ALU_Out, ALU_Hi;
    logic [1:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_hs_core #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .ALU_Hi    (ALU_Hi),
        .CarryOut  (CarryOut),
        .Zero      (Zero),
        .DivByZero (DivByZero),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        int k = 0;
        @(negedge clock);
        while (!in_ready && k < 30) begin
            @(negedge clock);
            k++;
        end
        check("send_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        ALU_Sel  = sel;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        A        = 8'($urandom_range(0, 255));
        B        = 8'($urandom_range(0, 255));
        ALU_Sel  = 4'($urandom_range(0, 15));
    endtask

    task automatic expect_result(input string tag, input logic [7:0] o, input logic [7:0] h,
                                 input logic c, input logic z, input logic d);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"},   ALU_Out, o);
        check({tag, "_hi"},    ALU_Hi, h);
        check({tag, "_carry"}, CarryOut, c);
        check({tag, "_zero"},  Zero, z);
        check({tag, "_dbz"},   DivByZero, d);
    endtask

    task automatic expect_taken(input string tag);
        @(negedge clock);
        check({tag, "_taken_valid"}, out_valid, 1'b0);
        check({tag, "_taken_ready"}, in_ready, 1'b1);
    endtask

    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel, input logic [7:0] o, input logic [7:0] h,
                          input logic c, input logic z, input logic d);
        send(a, b, sel);
        @(negedge clock);
        expect_result(tag, o, h, c, z, d);
        expect_taken(tag);
    endtask

    task automatic div_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r);
        send(a, b, 4'b1000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check({tag, "_busy_valid"}, out_valid, 1'b0);
            check({tag, "_busy_ready"}, in_ready, 1'b0);
            @(posedge clock);
        end
        @(negedge clock);
        expect_result(tag, q, r, 1'b0, (q == 8'd0), 1'b0);
        expect_taken(tag);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_out",   ALU_Out, 8'h00);
        check("rst_hi",    ALU_Hi, 8'h00);
        check("rst_carry", CarryOut, 1'b0);
        check("rst_zero",  Zero, 1'b0);
        check("rst_dbz",   DivByZero, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", in_ready, 1'b1);

        single("add",        8'd200, 8'd100, 4'b0001, 8'h2C, 8'h00, 1'b1, 1'b0, 1'b0);
        single("add_wrap",   8'd255, 8'd1,   4'b0001, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        single("sub_borrow", 8'd5,   8'd10,  4'b0010, 8'hFB, 8'h00, 1'b1, 1'b0, 1'b0);
        single("sub_zero",   8'd7,   8'd7,   4'b0010, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        single("mul",        8'd20,  8'd20,  4'b0100, 8'h90, 8'h01, 1'b1, 1'b0, 1'b0);
        single("mul_small",  8'd3,   8'd5,   4'b0100, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
        single("def_0011",   8'd20,  8'd20,  4'b0011, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        single("def_0000",   8'd1,   8'd2,   4'b0000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

        div_op("div",       8'd200, 8'd7,  8'd28,  8'd4);
        div_op("div_by1",   8'd255, 8'd1,  8'd255, 8'd0);
        div_op("div_small", 8'd3,   8'd10, 8'd0,   8'd3);
        single("div0",      8'h55,  8'h00, 4'b1000, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1);

        // Back-pressure: result must sit still while a stray request is ignored.
        out_ready = 1'b0;
        send(8'd3, 8'd4, 4'b0001);
        @(negedge clock);
        expect_result("bp", 8'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        A        = 8'd9;
        B        = 8'd9;
        ALU_Sel  = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            expect_result("bp_hold", 8'd7, 8'h00, 1'b0, 1'b0, 1'b0);
            check("bp_hold_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_taken("bp");
        @(negedge clock);
        check("bp_not_queued", out_valid, 1'b0);
        check("bp_out_kept",   ALU_Out, 8'd7);

        // Reset three cycles into a division.
        send(8'd200, 8'd7, 4'b1000);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_out",   ALU_Out, 8'h00);
        check("mid_rst_hi",    ALU_Hi, 8'h00);
        check("mid_rst_carry", CarryOut, 1'b0);
        check("mid_rst_zero",  Zero, 1'b0);
        check("mid_rst_dbz",   DivByZero, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("post_rst_no_valid", out_valid, 1'b0);
        end
        single("add_after_rst", 8'd1, 8'd1, 4'b0001, 8'd2, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_hs_core.md
Name: alu_hs_core

Overview:
- Parametrised successor to the team's registered 8-bit ALU.
- Operand width is generic. Operands are accepted through a valid/ready handshake, and results are returned through a valid/ready handshake with back-pressure.
- Division is an iterative restoring divider; every other op completes in one cycle.
- Adds a high-half/remainder output plus Zero and DivByZero flags. Sits between the sequencer front-end and the result scoreboard.

Parameters:
- WIDTH, 8: operand/result width, min 2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand/op request valid
- in_ready  out  1  block can accept a request
- A  in  WIDTH  operand A (unsigned)
- B  in  WIDTH  operand B (unsigned)
- ALU_Sel  in  4  op select, one-hot: 0001 add, 0010 sub, 0100 mul, 1000 div; any other value is the default op
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALU_Out  out  WIDTH  primary result
- ALU_Hi  out  WIDTH  mul high half / div remainder, else 0
- CarryOut  out  1  carry/borrow/overflow flag
- Zero  out  1  ALU_Out == 0
- DivByZero  out  1  div with B == 0

Behaviour:
- Reset (async assert, sync-free release):
  - State goes to IDLE, any division in progress is aborted.
  - out_valid=0, ALU_Out=0, ALU_Hi=0, CarryOut=0, Zero=0, DivByZero=0.
  - in_ready=0 while reset is high.
- FSM states IDLE, DIV, HOLD.
  - in_ready = (state==IDLE) & ~reset.
  - out_valid = (state==HOLD).
- Accept: in_valid & in_ready at a rising edge. A, B and ALU_Sel are captured on that edge; input changes afterwards are ignored.
- Single-cycle ops (add/sub/mul/default, and div with B==0): results are registered on the accept edge. State goes IDLE->HOLD, so out_valid is high in the next cycle (latency 1).
- Result rules (all arithmetic unsigned, truncated to WIDTH):
  - add: ALU_Out=(A+B) mod 2^WIDTH; CarryOut=bit WIDTH of {0,A}+{0,B}; ALU_Hi=0.
  - sub: ALU_Out=(A-B) mod 2^WIDTH; CarryOut=1 iff A<B (borrow); ALU_Hi=0.
  - mul: 2*WIDTH product; ALU_Out=low half, ALU_Hi=high half; CarryOut=1 iff high half != 0.
  - div, B!=0: ALU_Out=A/B, ALU_Hi=A%B, CarryOut=0.
  - div, B==0: ALU_Out=all ones, ALU_Hi=A, DivByZero=1, CarryOut=0, latency 1 (no iteration).
  - default (ALU_Sel not one-hot, incl. 0000): ALU_Out=all ones, ALU_Hi=0, CarryOut=0.
  - Zero is computed from the final ALU_Out for every op.
  - DivByZero=0 for every op other than div-by-zero.
- Division, B!=0:
  - Accept edge loads the dividend, divisor, partial remainder=0 and iteration counter=WIDTH; state goes IDLE->DIV.
  - Each edge in DIV produces one quotient bit, MSB first (restoring: shift, trial subtract, keep if non-negative).
  - The edge on which the counter reaches 0 writes the outputs and goes DIV->HOLD.
  - out_valid rises WIDTH+1 cycles after the accept edge (9 for WIDTH=8).
  - in_ready=0 throughout DIV.
- HOLD:
  - All result outputs are stable while out_valid=1 and out_ready=0, indefinitely.
  - Edge with out_ready=1: go HOLD->IDLE, out_valid falls, in_ready rises the next cycle.
  - Result outputs keep their last values in IDLE and DIV; only out_valid qualifies them.
- No overlap: at most one request in flight. Single-cycle op throughput is 1 per 2 cycles.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; the request is not queued.
- Reset mid-DIV or mid-HOLD: the result is discarded, no out_valid pulse; the first request after reset release is handled normally.

Test Plan (WIDTH=8):
- Add: A=200, B=100, ALU_Sel=0001, out_ready=1 -> next cycle out_valid=1, ALU_Out=0x2C, CarryOut=1, ALU_Hi=0, Zero=0; in_ready returns to 1 one cycle after the result is taken.
- Sub: A=5, B=10 -> ALU_Out=0xFB, CarryOut=1. Sub: A=7, B=7 -> ALU_Out=0, Zero=1, CarryOut=0.
- Mul and default: A=20, B=20, ALU_Sel=0100 -> ALU_Out=0x90, ALU_Hi=0x01, CarryOut=1. ALU_Sel=0011 -> ALU_Out=0xFF, ALU_Hi=0.
- Div: A=200, B=7, ALU_Sel=1000 -> in_ready low and out_valid low for 8 cycles, then out_valid=1 exactly 9 cycles after accept with ALU_Out=28, ALU_Hi=4. Also A=255, B=1 -> 255 rem 0 in 9 cycles.
- Div by zero: A=0x55, B=0 -> out_valid after 1 cycle, ALU_Out=0xFF, ALU_Hi=0x55, DivByZero=1.
- Back-pressure and reset:
  - Hold out_ready=0 for 5 cycles after an add -> outputs unchanged, in_ready=0, extra in_valid ignored.
  - Assert reset 3 cycles into a div -> all outputs 0 immediately, no out_valid; the next add after release completes with latency 1.
